// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hazard_state_e;

    localparam int TIMEOUT_W = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The slave modport is the controller; the master modport is the pipeline.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             IDEXMemRead;
    logic [4:0]       IDEXRt;
    logic [4:0]       IFIDRs;
    logic [4:0]       IFIDRt;
    logic             BranchTaken;
    logic             MemReq;
    logic             MemReady;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic             PipeFreeze;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic [CNT_W-1:0] FreezeCount;

    modport master (
        output IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, BranchTaken, MemReq, MemReady,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, MemTimeout,
        input  StallCount, FlushCount, FreezeCount
    );

    modport slave (
        input  IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, BranchTaken, MemReq, MemReady,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze, MemTimeout,
        output StallCount, FlushCount, FreezeCount
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in ID/EX writing a register read by IF/ID.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign load_use = mem_read && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freezes.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0]           FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(MEM_TIMEOUT);

    hazard_state_e          state_q, state_d;
    logic [1:0]             rem_q, rem_d;
    logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;

    logic load_use;
    logic freeze;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;

    hazard_detect u_detect (
        .mem_read (hz.IDEXMemRead),
        .idex_rt  (hz.IDEXRt),
        .ifid_rs  (hz.IFIDRs),
        .ifid_rt  (hz.IFIDRt),
        .load_use (load_use)
    );

    assign freeze = hz.MemReq && !hz.MemReady;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            state_d     = MEM_WAIT;
        end else begin
            case (state_q)
                FLUSH: begin
                    ifid_flush = 1'b1;
                    rem_d      = rem_q - 2'd1;
                    if (rem_d == 2'd0) state_d = RUN;
                end
                // RUN, LOAD_STALL and a ready MEM_WAIT share RUN's decisions;
                // LOAD_STALL skips loaduse because the bubble already cleared ID/EX.
                default: begin
                    if (load_use && state_q != LOAD_STALL) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = LOAD_STALL;
                    end else if (hz.BranchTaken) begin
                        ifid_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            rem_d   = FLUSH_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            endcase
        end
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            pipe_freeze = 1'b0;
        end
    end

    // Timeout counts only consecutive MEM_WAIT freeze cycles; any ready cycle restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == MEM_WAIT && freeze) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + TIMEOUT_W'(1);
        end
        timeout_d = timeout_q || (wait_cnt_d == TIMEOUT_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            rem_q      <= 2'd0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFIDWrite  = ifid_write;
    assign hz.IFIDFlush  = ifid_flush;
    assign hz.IDEXBubble = idex_bubble;
    assign hz.PipeFreeze = pipe_freeze;
    assign hz.MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (idex_bubble && stall_cnt_q != '1)   stall_cnt_d  = stall_cnt_q + CNT_W'(1);
        if (ifid_flush && flush_cnt_q != '1)    flush_cnt_d  = flush_cnt_q + CNT_W'(1);
        if (pipe_freeze && freeze_cnt_q != '1)  freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign hz.StallCount  = stall_cnt_q;
    assign hz.FlushCount  = flush_cnt_q;
    assign hz.FreezeCount = freeze_cnt_q;
`else
    assign hz.StallCount  = {CNT_W{1'b0}};
    assign hz.FlushCount  = {CNT_W{1'b0}};
    assign hz.FreezeCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(16)) hz_if ();

    hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (4),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_hz(input string tag, input logic pcw, input logic ifw,
                            input logic fl, input logic bub, input logic frz);
        check_output({tag, ".PCWrite"},    32'(hz_if.PCWrite),    32'(pcw));
        check_output({tag, ".IFIDWrite"},  32'(hz_if.IFIDWrite),  32'(ifw));
        check_output({tag, ".IFIDFlush"},  32'(hz_if.IFIDFlush),  32'(fl));
        check_output({tag, ".IDEXBubble"}, 32'(hz_if.IDEXBubble), 32'(bub));
        check_output({tag, ".PipeFreeze"}, 32'(hz_if.PipeFreeze), 32'(frz));
    endtask

    task automatic check_counts(input string tag, input int st, input int fl, input int fr);
        check_output({tag, ".StallCount"},  32'(hz_if.StallCount),  PERF ? 32'(st) : 32'd0);
        check_output({tag, ".FlushCount"},  32'(hz_if.FlushCount),  PERF ? 32'(fl) : 32'd0);
        check_output({tag, ".FreezeCount"}, 32'(hz_if.FreezeCount), PERF ? 32'(fr) : 32'd0);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 2 ns later.
    task automatic apply_stimulus(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic br, input logic req,
                                  input logic rdy);
        @(negedge clk);
        hz_if.IDEXMemRead = mr;
        hz_if.IDEXRt      = rt_ex;
        hz_if.IFIDRs      = rs;
        hz_if.IFIDRt      = rt;
        hz_if.BranchTaken = br;
        hz_if.MemReq      = req;
        hz_if.MemReady    = rdy;
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        hz_if.IDEXMemRead = 1'b0;
        hz_if.IDEXRt      = 5'd0;
        hz_if.IFIDRs      = 5'd0;
        hz_if.IFIDRt      = 5'd0;
        hz_if.BranchTaken = 1'b0;
        hz_if.MemReq      = 1'b0;
        hz_if.MemReady    = 1'b0;
        #2;
        check_hz("reset", 0, 0, 0, 1, 0);
        check_output("reset.MemTimeout", 32'(hz_if.MemTimeout), 32'd0);
        check_counts("reset", 0, 0, 0);

        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("idle", 1, 1, 0, 0, 0);

        apply_stimulus(1, 5, 5, 0, 0, 0, 0);
        check_hz("loaduse_rs", 0, 0, 0, 1, 0);
        apply_stimulus(1, 5, 5, 0, 0, 0, 0);
        check_hz("loaduse_held", 1, 1, 0, 0, 0);
        check_counts("loaduse_held", 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("loaduse_done", 1, 1, 0, 0, 0);

        apply_stimulus(1, 0, 0, 0, 0, 0, 0);
        check_hz("reg_zero", 1, 1, 0, 0, 0);
        apply_stimulus(0, 7, 3, 7, 0, 0, 0);
        check_hz("no_load", 1, 1, 0, 0, 0);
        apply_stimulus(1, 7, 3, 7, 0, 0, 0);
        check_hz("loaduse_rt", 0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("loaduse_rt_next", 1, 1, 0, 0, 0);
        check_counts("loaduse_rt_next", 2, 0, 0);

        apply_stimulus(0, 0, 0, 0, 1, 0, 0);
        check_hz("branch_c1", 1, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("branch_c2", 1, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("branch_done", 1, 1, 0, 0, 0);
        check_counts("branch_done", 2, 2, 0);

        apply_stimulus(1, 9, 9, 0, 1, 0, 0);
        check_hz("prio_stall", 0, 0, 0, 1, 0);
        apply_stimulus(1, 9, 9, 0, 1, 0, 0);
        check_hz("prio_branch", 1, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("prio_flush2", 1, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("prio_done", 1, 1, 0, 0, 0);
        check_counts("prio_done", 3, 4, 0);

        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 1, 0);
            check_hz($sformatf("freeze_c%0d", i), 0, 0, 0, 0, 1);
            check_output($sformatf("freeze_c%0d.MemTimeout", i), 32'(hz_if.MemTimeout),
                         (i == 6) ? 32'd1 : 32'd0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        check_hz("freeze_ready", 1, 1, 0, 0, 0);
        check_output("freeze_ready.MemTimeout", 32'(hz_if.MemTimeout), 32'd1);
        check_counts("freeze_ready", 3, 4, 6);

        apply_stimulus(1, 4, 4, 0, 0, 1, 0);
        check_hz("freeze_over_loaduse", 0, 0, 0, 0, 1);
        apply_stimulus(1, 4, 4, 0, 0, 1, 1);
        check_hz("loaduse_after_freeze", 0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("after_freeze_stall", 1, 1, 0, 0, 0);
        check_output("sticky.MemTimeout", 32'(hz_if.MemTimeout), 32'd1);
        check_counts("after_freeze_stall", 4, 4, 7);

        apply_stimulus(0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("in_flush", 1, 1, 1, 0, 0);
        #1 reset = 1'b1;
        #1;
        check_hz("mid_reset", 0, 0, 0, 1, 0);
        check_output("mid_reset.MemTimeout", 32'(hz_if.MemTimeout), 32'd0);
        check_counts("mid_reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_hz("post_reset_run", 1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
